// File: rtl/fp_addsub.sv
// rtl/fp_addsub.sv - multi-cycle IEEE-style floating-point adder/subtractor
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 inv
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int D  = MAN_W + 4;
    localparam int XW = EXP_W + $clog2(MAN_W + 4) + 2;
    localparam logic [EXP_W-1:0]     EMAX   = '1;
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X = '0;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;
    typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

    state_t state, state_n;
    kind_t  kind, kind_u;
    logic [W-1:0]          ra, rb;
    logic                  rop, sgn, sml_s, ovf_p;
    logic signed [XW-1:0]  ex, ex_n, ex_r;
    logic [D:0]            mt, mt_n, sum;
    logic [D-1:0]          sml_m, mask, al;
    logic [EXP_W-1:0]      dif, ea, eb;
    logic [MAN_W-1:0]      fa, fb, frac_r;
    logic [MAN_W:0]        ma, mb;
    logic [MAN_W+1:0]      mr;
    logic [31:0]           sh;
    logic                  sa, sb, a_ge, sgn_u, nan_a, nan_b, inf_a, inf_b, inc;
    int                    lz;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_UNPACK;
            S_UNPACK: state_n = S_ALIGN;
            S_ALIGN:  state_n = S_ADD;
            S_ADD:    state_n = S_NORM;
            S_NORM:   state_n = S_ROUND;
            default:  state_n = S_IDLE;
        endcase
    end

    // Unpack: flush denormals, order operands by magnitude, classify specials
    always_comb begin
        sa = ra[W-1];       ea = ra[W-2:MAN_W]; fa = ra[MAN_W-1:0];
        sb = rb[W-1] ^ rop; eb = rb[W-2:MAN_W]; fb = rb[MAN_W-1:0];
        ma = (ea == '0) ? '0 : {1'b1, fa};
        mb = (eb == '0) ? '0 : {1'b1, fb};
        nan_a = (ea == EMAX) && (fa != '0);
        nan_b = (eb == EMAX) && (fb != '0);
        inf_a = (ea == EMAX) && (fa == '0);
        inf_b = (eb == EMAX) && (fb == '0);
        a_ge  = {ea, ma} >= {eb, mb};
        kind_u = K_NUM;
        sgn_u  = a_ge ? sa : sb;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            kind_u = K_NAN;
            sgn_u  = 1'b0;
        end else if (inf_a) begin
            kind_u = K_INF;
            sgn_u  = sa;
        end else if (inf_b) begin
            kind_u = K_INF;
            sgn_u  = sb;
        end
    end

    // Align with saturating shift; every bit shifted out collapses into sticky
    always_comb begin
        sh   = (32'(dif) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(dif);
        mask = (D'(1) << sh) - D'(1);
        al   = (sml_m >> sh) | D'(|(sml_m & mask));
        sum  = (sgn == sml_s) ? mt + {1'b0, sml_m} : mt - {1'b0, sml_m};
    end

    always_comb begin
        lz = 0;
        for (int i = 0; i < D; i++)
            if (mt[i]) lz = D - 1 - i;
        if (mt[D]) begin
            mt_n = {1'b0, mt[D:2], mt[1] | mt[0]};
            ex_n = ex + ONE_X;
        end else begin
            mt_n = {1'b0, mt[D-1:0] << lz};
            ex_n = ex - XW'(lz);
        end
    end

    always_comb begin
`ifdef FP_ADDSUB_RNE_EN
        inc = mt[2] & (mt[1] | mt[0] | mt[3]);
`else
        inc = 1'b0;
`endif
        mr = {1'b0, mt[D-1:3]} + (MAN_W+2)'(inc);
        if (mr[MAN_W+1]) begin
            frac_r = mr[MAN_W:1];
            ex_r   = ex + ONE_X;
        end else begin
            frac_r = mr[MAN_W-1:0];
            ex_r   = ex;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            inv    <= 1'b0;
            ra     <= '0;
            rb     <= '0;
            rop    <= 1'b0;
            kind   <= K_ZERO;
            sgn    <= 1'b0;
            sml_s  <= 1'b0;
            ovf_p  <= 1'b0;
            ex     <= '0;
            mt     <= '0;
            sml_m  <= '0;
            dif    <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_n != S_IDLE) || (state == S_ROUND);
            case (state)
                S_IDLE: if (start) begin
                    ra  <= a;
                    rb  <= b;
                    rop <= op;
                end
                S_UNPACK: begin
                    kind  <= kind_u;
                    sgn   <= sgn_u;
                    ovf_p <= 1'b0;
                    sml_s <= a_ge ? sb : sa;
                    ex    <= XW'(a_ge ? ea : eb);
                    mt    <= {1'b0, a_ge ? ma : mb, 3'b000};
                    sml_m <= {a_ge ? mb : ma, 3'b000};
                    dif   <= a_ge ? ea - eb : eb - ea;
                end
                S_ALIGN: sml_m <= al;
                S_ADD: if (kind == K_NUM) begin
                    mt <= sum;
                    if (sum == '0) begin
                        kind <= K_ZERO;
                        sgn  <= sgn & sml_s;
                    end
                end
                S_NORM: if (kind == K_NUM) begin
                    mt <= mt_n;
                    ex <= ex_n;
                    if (ex_n >= EMAX_X) begin
                        kind  <= K_INF;
                        ovf_p <= 1'b1;
                    end else if (ex_n <= ZERO_X) begin
                        kind <= K_ZERO;
                    end
                end
                S_ROUND: begin
                    done <= 1'b1;
                    inv  <= (kind == K_NAN);
                    ovf  <= 1'b0;
                    case (kind)
                        K_NAN:  result <= {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
                        K_INF: begin
                            result <= {sgn, EMAX, {MAN_W{1'b0}}};
                            ovf    <= ovf_p;
                        end
                        K_ZERO: result <= {sgn, {(EXP_W+MAN_W){1'b0}}};
                        default: begin
                            if (ex_r >= EMAX_X) begin
                                result <= {sgn, EMAX, {MAN_W{1'b0}}};
                                ovf    <= 1'b1;
                            end else begin
                                result <= {sgn, ex_r[EXP_W-1:0], frac_r};
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub.sv
// tb/tb_fp_addsub.sv - scoreboard bench for fp_addsub (single precision)
// Follows FP_ADDSUB_RNE_EN to pick the rounding mode of the reference model.
module tb_fp_addsub;
`ifdef FP_ADDSUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] a, b, result;
    logic        busy, done, ovf, inv;

    fp_addsub #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .busy(busy), .done(done), .ovf(ovf), .inv(inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        i;
        int          t;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_fail = 0, n_done = 0, busy_cnt = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact-arithmetic reference: returns {ovf, inv, result}
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
        logic sx = x[31], sy = y[31] ^ o, sg;
        int ex = int'(x[30:23]), ey = int'(y[30:23]), e0, e, p, sh;
        logic [127:0] mx, my, s, mant, rem, half;
        bit nanx = (ex == 255) && (x[22:0] != 0), nany = (ey == 255) && (y[22:0] != 0);
        bit infx = (ex == 255) && (x[22:0] == 0), infy = (ey == 255) && (y[22:0] == 0);
        if (nanx || nany || (infx && infy && (sx != sy))) return {2'b01, 32'h7FC00000};
        if (infx) return {2'b00, sx, 31'h7F800000};
        if (infy) return {2'b00, sy, 31'h7F800000};
        if (ex == 0 && ey == 0) return {2'b00, sx & sy, 31'h0};
        if (ey == 0) return {2'b00, x};
        if (ex == 0) return {2'b00, sy, y[30:0]};
        e0 = (ex < ey) ? ex : ey;
        mx = {105'b0, 1'b1, x[22:0]} << (ex - e0);
        my = {105'b0, 1'b1, y[22:0]} << (ey - e0);
        if (sx == sy)      begin s = mx + my; sg = sx; end
        else if (mx >= my) begin s = mx - my; sg = sx; end
        else               begin s = my - mx; sg = sy; end
        if (s == 0) return 34'h0;
        p = 127;
        while (!s[p]) p--;
        e = e0 + p - 23;
        if (e >= 255) return {2'b10, sg, 31'h7F800000};
        if (e <= 0) return {2'b00, sg, 31'h0};
        if (p > 23) begin
            sh   = p - 23;
            mant = s >> sh;
            rem  = s & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            if (RNE && ((rem > half) || (rem == half && mant[0]))) mant = mant + 128'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e++;
            end
        end else begin
            mant = s << (23 - p);
        end
        if (e >= 255) return {2'b10, sg, 31'h7F800000};
        return {2'b00, sg, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp(input int ec);
        int sel = int'($urandom_range(0, 31));
        int e;
        logic [22:0] f = 23'($urandom);
        if ($urandom_range(0, 3) == 0) f[10:0] = '0;
        if (sel == 0)      e = 0;
        else if (sel == 1) begin e = 255; f = '0; end
        else if (sel == 2) begin e = 255; f[0] = 1'b1; end
        else begin
            e = ec + int'($urandom_range(0, 100)) - 50;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end
        return {1'($urandom), 8'(e), f};
    endfunction

    always @(negedge clk) begin
        exp_t ex;
        if (done) begin
            n_done++;
            chk("busy_in_done_cycle", 32'(busy), 32'd1);
            chk("busy_cycles_before_done", 32'(busy_cnt), 32'd5);
            busy_cnt = 0;
            chk("scoreboard_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                ex = sb_q.pop_front();
                chk("result", result, ex.r);
                chk("ovf", 32'(ovf), 32'(ex.o));
                chk("inv", 32'(inv), 32'(ex.i));
                chk("latency", 32'(cyc - ex.t), 32'd5);
            end
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic push_exp(input logic [31:0] x, input logic [31:0] y, input logic o, input int t);
        logic [33:0] m = model(x, y, o);
        sb_q.push_back('{r: m[31:0], o: m[33], i: m[32], t: t});
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50 && busy; n++) @(negedge clk);
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb_q.size() > 0; n++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic o,
                         input logic [31:0] er, input logic eo, input logic ei);
        wait_idle();
        a = x; b = y; op = o; start = 1'b1;
        sb_q.push_back('{r: er, o: eo, i: ei, t: cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_rand(input logic [31:0] x, input logic [31:0] y, input logic o);
        wait_idle();
        a = x; b = y; op = o; start = 1'b1;
        push_exp(x, y, o, cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [31:0] x, y;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_flags", {30'd0, ovf, inv}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        issue(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0);
        issue(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        issue(32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 1'b0, 1'b0);
        drain();
        wait_idle();

        // Abort in ALIGN with start held through the reset cycle
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("abort_result", result, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", {30'd0, ovf, inv}, 32'd0);
        d0 = n_done;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", 32'(n_done), 32'(d0));
        issue(32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        drain();
        wait_idle();

        // Start held high across three operations
        d0 = n_done;
        x = rnd_fp(127); y = rnd_fp(127);
        a = x; b = y; op = 1'b0; start = 1'b1;
        push_exp(x, y, 1'b0, cyc + 1);
        @(negedge clk);
        for (int i = 1; i < 3; i++) begin
            x = rnd_fp(127); y = rnd_fp(127);
            a = x; b = y; op = 1'(i);
            push_exp(x, y, 1'(i), cyc + 6);
            repeat (6) @(negedge clk);
        end
        start = 1'b0;
        drain();
        chk("burst_done_count", 32'(n_done - d0), 32'd3);

        for (int i = 0; i < 250; i++) begin
            int ec = int'($urandom_range(1, 254));
            x = rnd_fp(ec);
            y = rnd_fp(ec);
            if ($urandom_range(0, 7) == 0) y = x ^ {1'($urandom), 29'd0, 2'($urandom)};
            issue_rand(x, y, 1'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (>=3).
REQ-002 Parameter MAN_W, default 23, stored fraction width (>=4); word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 op  input  1  0 = a+b, 1 = a-b; captured with operands.
REQ-007 a  input  W  operand A, IEEE-754-style layout {sign, exp, frac}.
REQ-008 b  input  W  operand B, same layout.
REQ-009 result  output  W  registered sum/difference, held until next done.
REQ-010 busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse, result and flags valid.
REQ-012 ovf  output  1  overflow flag, valid with done, held until next done.
REQ-013 inv  output  1  invalid-operation flag, valid with done, held until next done.

Function
REQ-014 FSM states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND; each non-IDLE state lasts exactly one cycle.
REQ-015 start=1 in IDLE at edge k: a, b, op captured, state UNPACK; done=1 in the cycle after edge k+5 (fixed latency 5), state back to IDLE same edge.
REQ-016 start while busy=1 ignored; no queuing; back-to-back start accepted in the done cycle (done and new capture on same edge pair).
REQ-017 UNPACK: op=1 inverts effective sign of b; exp=0 operands treated as signed zero (denormals flushed to zero); hidden bit 1 for non-zero.
REQ-018 ALIGN: smaller-exponent mantissa right-shifted by exponent difference into MAN_W+4 bit datapath (guard, round, sticky); shift saturates at MAN_W+3, shifted-out bits ORed into sticky.
REQ-019 ADD: same effective signs add magnitudes; differing signs subtract smaller magnitude from larger, result sign = sign of larger; carry-out kept.
REQ-020 NORM: carry-out -> shift right 1, exponent+1 (sticky preserved); otherwise left-shift by leading-zero count, exponent decremented, single cycle.
REQ-021 ROUND: per Configuration; rounding carry renormalises, exponent+1.
REQ-022 Exact zero from cancellation -> +0; (-0)+(-0) -> -0; x+0 -> x exactly.
REQ-023 Biased exponent reaching all-ones after NORM/ROUND -> +/-infinity, ovf=1.
REQ-024 Biased exponent <=0 after NORM -> signed zero (flush), ovf=0.
REQ-025 Any NaN input, or inf+(-inf) effective -> canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0), inv=1.
REQ-026 Infinity with finite operand -> that infinity, flags 0.

Reset
REQ-027 reset=1 at an edge: state IDLE, result=0, busy=0, done=0, ovf=0, inv=0; in-flight operation discarded; reset dominates start.

Configuration
REQ-028 Macro FP_ADDSUB_RNE_EN defined: ROUND performs round-to-nearest, ties-to-even using guard/round/sticky.
REQ-029 FP_ADDSUB_RNE_EN undefined: ROUND truncates toward zero; ROUND state retained, latency unchanged.

Verification (EXP_W=8, MAN_W=23)
REQ-030 a=0x3F800000, b=0x3F800000, op=0, start 1 cycle -> busy 5 cycles, done pulse at latency 5, result=0x40000000, ovf=0, inv=0.
REQ-031 a=0x3FC00000, b=0x3FC00000, op=1 -> result=0x00000000; a=0x80000000, b=0x00000000, op=1 -> result=0x80000000.
REQ-032 a=0x7F800000, b=0xFF800000, op=0 -> result=0x7FC00000, inv=1; a=0x7F7FFFFF, b=0x7F7FFFFF -> result=0x7F800000, ovf=1.
REQ-033 a=0x3F800001, b=0x33800000, op=0 -> result=0x3F800002 with FP_ADDSUB_RNE_EN, 0x3F800001 without.
REQ-034 start accepted, reset pulsed in ALIGN, released -> no done, outputs 0; next start 0x40000000+0xBF800000 -> result=0x3F800000 at latency 5.
REQ-035 start held high continuously over three operations -> exactly one done per 6 cycles, no dropped or duplicated results.
